uart_reg_ctrl: RTL

//  Host-command sequencer sitting on top of the byte-level UART in the image-reader design.

---
 rtl/uart_reg_ctrl_if.sv | 28 ++
 rtl/uart_reg_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_reg_ctrl_if.sv
// Bundles the UART byte interface and the local register bus seen by uart_reg_ctrl.
// master = the command sequencer, slave = UART plus register file.
interface uart_reg_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              uart_rx_ready;
  logic [7:0]        uart_rx_data;
  logic              uart_tx_start;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_busy;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_rd_ack;

  modport master (
    input  uart_rx_ready, uart_rx_data, uart_tx_busy, reg_rdata, reg_rd_ack,
    output uart_tx_start, uart_tx_data, reg_wr_en, reg_rd_en, reg_addr, reg_wdata
  );

  modport slave (
    output uart_rx_ready, uart_rx_data, uart_tx_busy, reg_rdata, reg_rd_ack,
    input  uart_tx_start, uart_tx_data, reg_wr_en, reg_rd_en, reg_addr, reg_wdata
  );
endinterface

// File: rtl/uart_reg_ctrl.sv
// Host command sequencer: parses SYNC/CMD/ADDR/DATA frames from the UART, performs one
// register access and streams the ACK/NACK response back out through the UART.
module uart_reg_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_BYTES  = 2,
  parameter int unsigned TIMEOUT_CYC = 125000
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_reg_ctrl_if.master bus,
  output logic            busy,
  output logic            err_pulse
);
  localparam int unsigned DataW   = 8 * DATA_BYTES;
  localparam int unsigned TxW     = DataW + 8;
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CntW    = $clog2(DATA_BYTES + 2);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] LastByte = CntW'(DATA_BYTES - 1);
  localparam logic [CntW-1:0] RdRspLen = CntW'(DATA_BYTES + 1);
  localparam logic [7:0] Sync = 8'h55;
  localparam logic [7:0] Ack  = 8'hAA;
  localparam logic [7:0] Nack = 8'hEE;

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddr, StWdata, StRegWr, StRegRd, StTxLoad, StTxWaitHi, StTxWaitLo
  } state_e;

  state_e           state_q;
  logic             rx_ready_q;
  logic             is_read_q;
  logic [CntW-1:0]  byte_cnt_q;
  logic [CntW-1:0]  tx_cnt_q;
  logic [TmoW-1:0]  tmo_cnt_q;
  logic [TxW-1:0]   tx_buf_q;
  logic             byte_ev;
  logic             tmo_hit;
  logic             in_busy_phase;

  assign byte_ev = bus.uart_rx_ready & ~rx_ready_q;
  // A byte arriving on the terminal count wins over the timeout.
  assign tmo_hit = (tmo_cnt_q == TmoLast) & ~byte_ev;
  assign busy    = (state_q != StIdle);
  assign in_busy_phase = (state_q == StRegWr) || (state_q == StRegRd) ||
                         (state_q == StTxLoad) || (state_q == StTxWaitHi) ||
                         (state_q == StTxWaitLo);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      rx_ready_q        <= 1'b0;
      is_read_q         <= 1'b0;
      byte_cnt_q        <= '0;
      tx_cnt_q          <= '0;
      tmo_cnt_q         <= '0;
      tx_buf_q          <= '0;
      bus.uart_tx_start <= 1'b0;
      bus.uart_tx_data  <= '0;
      bus.reg_wr_en     <= 1'b0;
      bus.reg_rd_en     <= 1'b0;
      bus.reg_addr      <= '0;
      bus.reg_wdata     <= '0;
      err_pulse         <= 1'b0;
    end else begin
      rx_ready_q        <= bus.uart_rx_ready;
      bus.uart_tx_start <= 1'b0;
      bus.reg_wr_en     <= 1'b0;
      bus.reg_rd_en     <= 1'b0;
      err_pulse         <= byte_ev & in_busy_phase;
      tmo_cnt_q         <= byte_ev ? '0 : tmo_cnt_q + TmoW'(1);

      unique case (state_q)
        StIdle: begin
          tmo_cnt_q <= '0;
          if (byte_ev && bus.uart_rx_data == Sync) state_q <= StCmd;
        end
        StCmd: begin
          if (byte_ev) begin
            if (bus.uart_rx_data == 8'h01 || bus.uart_rx_data == 8'h02) begin
              is_read_q <= (bus.uart_rx_data == 8'h02);
              state_q   <= StAddr;
            end else begin
              tx_buf_q  <= {Nack, {DataW{1'b0}}};
              tx_cnt_q  <= CntW'(1);
              err_pulse <= 1'b1;
              state_q   <= StTxLoad;
            end
          end else if (tmo_hit) begin
            err_pulse <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StAddr: begin
          if (byte_ev) begin
            bus.reg_addr <= ADDR_W'(bus.uart_rx_data);
            if (is_read_q) begin
              bus.reg_rd_en <= 1'b1;
              state_q       <= StRegRd;
            end else begin
              byte_cnt_q <= '0;
              state_q    <= StWdata;
            end
          end else if (tmo_hit) begin
            err_pulse <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StWdata: begin
          if (byte_ev) begin
            bus.reg_wdata <= (bus.reg_wdata << 8) | DataW'(bus.uart_rx_data);
            if (byte_cnt_q == LastByte) begin
              bus.reg_wr_en <= 1'b1;
              state_q       <= StRegWr;
            end else begin
              byte_cnt_q <= byte_cnt_q + CntW'(1);
            end
          end else if (tmo_hit) begin
            err_pulse <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StRegWr: begin
          tmo_cnt_q <= '0;
          tx_buf_q  <= {Ack, {DataW{1'b0}}};
          tx_cnt_q  <= CntW'(1);
          state_q   <= StTxLoad;
        end
        StRegRd: begin
          // reg_rd_en still high means this is the strobe cycle; an ack there is ignored.
          if (bus.reg_rd_ack && !bus.reg_rd_en) begin
            tmo_cnt_q <= '0;
            tx_buf_q  <= {Ack, bus.reg_rdata};
            tx_cnt_q  <= RdRspLen;
            state_q   <= StTxLoad;
          end else if (tmo_hit) begin
            tmo_cnt_q <= '0;
            tx_buf_q  <= {Nack, {DataW{1'b0}}};
            tx_cnt_q  <= CntW'(1);
            err_pulse <= 1'b1;
            state_q   <= StTxLoad;
          end
        end
        StTxLoad: begin
          tmo_cnt_q <= '0;
          if (!bus.uart_tx_busy) begin
            bus.uart_tx_data  <= tx_buf_q[TxW-1 -: 8];
            bus.uart_tx_start <= 1'b1;
            tx_buf_q          <= tx_buf_q << 8;
            tx_cnt_q          <= tx_cnt_q - CntW'(1);
            state_q           <= StTxWaitHi;
          end
        end
        StTxWaitHi: begin
          tmo_cnt_q <= '0;
          if (bus.uart_tx_busy) state_q <= StTxWaitLo;
        end
        StTxWaitLo: begin
          tmo_cnt_q <= '0;
          if (!bus.uart_tx_busy) state_q <= (tx_cnt_q != '0) ? StTxLoad : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
